// File: rtl/lfm_chirp_ctrl.sv
// ---------------------------------------------------------------------------------------------
// lfm_chirp_ctrl
//
// Linear-FM chirp sequencer that drives the phase_increment input of a downstream NCO.
// A start pulse launches one chirp: phase_increment steps from f_start by k_step every clock
// for chirp_len samples, with first/last/done framing strobes. All outputs are registered.
//
// Ports:
//   i_clk              system clock
//   i_rst              asynchronous, active-high reset
//   i_start            one-cycle chirp launch request (honoured only in IDLE with len != 0)
//   i_abort            synchronous abort of a running chirp
//   i_f_start          phase increment of sample 0
//   i_k_step           two's-complement per-sample delta (sweep rate)
//   i_chirp_len        number of samples in the chirp
//   o_phase_increment  phase increment to the NCO; 0 whenever o_chirp_valid is 0
//   o_chirp_valid      high on every chirp sample
//   o_chirp_first      high on sample 0 only
//   o_chirp_last       high on sample chirp_len-1 only
//   o_busy             high whenever the sequencer is not idle
//   o_done             one-cycle completion pulse, the cycle after the last sample
// ---------------------------------------------------------------------------------------------
module lfm_chirp_ctrl #(
  parameter int PHASE_WIDTH = 32,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [PHASE_WIDTH-1:0] i_f_start,
  input  logic [PHASE_WIDTH-1:0] i_k_step,
  input  logic [LEN_WIDTH-1:0]   i_chirp_len,
  output logic [PHASE_WIDTH-1:0] o_phase_increment,
  output logic                   o_chirp_valid,
  output logic                   o_chirp_first,
  output logic                   o_chirp_last,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

  state_t                 r_state;
  logic [PHASE_WIDTH-1:0] r_k_step;
  // Samples still to come after the one currently presented; 0 means the current one is last.
  logic [LEN_WIDTH-1:0]   r_remain;
  // Running phase accumulator; doubles as the registered NCO word since it is only
  // non-zero while a sample is being presented.
  logic [PHASE_WIDTH-1:0] r_phase;
  logic                   r_valid;
  logic                   r_first;
  logic                   r_last;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_accept;
  logic                   w_len_is_one;
  logic                   w_cur_is_last;
  logic                   w_next_is_last;
  logic [LEN_WIDTH-1:0]   w_len_m1;

  assign w_accept       = i_start && (i_chirp_len != '0);
  assign w_len_is_one   = (i_chirp_len == LEN_WIDTH'(1));
  assign w_len_m1       = i_chirp_len - LEN_WIDTH'(1);
  assign w_cur_is_last  = (r_remain == '0);
  assign w_next_is_last = (r_remain == LEN_WIDTH'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_k_step <= '0;
      r_remain <= '0;
      r_phase  <= '0;
      r_valid  <= 1'b0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          // A zero-length request is dropped without touching any output.
          if (w_accept) begin
            r_state  <= StRun;
            r_k_step <= i_k_step;
            r_remain <= w_len_m1;
            r_phase  <= i_f_start;
            r_valid  <= 1'b1;
            r_first  <= 1'b1;
            r_last   <= w_len_is_one;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end
        end

        StRun: begin
          if (i_abort) begin
            // Abort wins over end-of-chirp: straight to idle, no done pulse.
            r_state  <= StIdle;
            r_remain <= '0;
            r_phase  <= '0;
            r_valid  <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
          end else if (w_cur_is_last) begin
            r_state <= StDone;
            r_phase <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            // Wrap-around of the accumulator is intentional (mod 2^PHASE_WIDTH).
            r_remain <= r_remain - LEN_WIDTH'(1);
            r_phase  <= r_phase + r_k_step;
            r_first  <= 1'b0;
            r_last   <= w_next_is_last;
          end
        end

        StDone: begin
          // Start and abort are both ignored here.
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state  <= StIdle;
          r_remain <= '0;
          r_phase  <= '0;
          r_valid  <= 1'b0;
          r_first  <= 1'b0;
          r_last   <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign o_phase_increment = r_phase;
  assign o_chirp_valid     = r_valid;
  assign o_chirp_first     = r_first;
  assign o_chirp_last      = r_last;
  assign o_busy            = r_busy;
  assign o_done            = r_done;

endmodule

// File: doc/lfm_chirp_ctrl.md
# lfm_chirp_ctrl

Linear-FM chirp sequencer that sits directly upstream of the NCO and drives its `phase_increment` input. It generates a linear ramp of phase increments, one per clock, so the NCO outputs the transmit and reference chirp for pulse compression. A start pulse launches one chirp of programmable length, start frequency and sweep rate. Framing strobes mark the first sample, the last sample and completion.

## Interface
Parameters:
- `PHASE_WIDTH`, 32: width of the phase-increment word; must match the NCO accumulator width.
- `LEN_WIDTH`, 16: width of the chirp-length field, giving at most 2^16−1 samples.

Ports:
- `clk` in 1: single system clock (100 MHz nominal).
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: one-cycle chirp launch request.
- `abort` in 1: synchronous abort of a chirp in progress.
- `f_start` in PHASE_WIDTH: increment of the first sample (start frequency × 2^PHASE_WIDTH / f_clk).
- `k_step` in PHASE_WIDTH: two's-complement delta added per sample (sweep rate).
- `chirp_len` in LEN_WIDTH: number of samples in the chirp.
- `phase_increment` out PHASE_WIDTH: registered output to the NCO `phase_increment` input.
- `chirp_valid` out 1: high on every chirp sample.
- `chirp_first` out 1: high on sample 0 only.
- `chirp_last` out 1: high on sample `chirp_len`−1 only.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - On `start`=1 with `chirp_len`≠0: latch `f_start`, `k_step` and `chirp_len`, then go to RUN.
  - On `start` with `chirp_len`=0: ignore the request and stay in IDLE; no output changes.
- **RUN**
  - Sample index i counts 0…len−1.
  - `phase_increment` = f_start + i·k_step mod 2^PHASE_WIDTH, implemented as a running accumulator that adds the latched `k_step` each cycle.
  - Wrap-around is silent, with no saturation.
  - At i = len−1, go to DONE.
- **DONE**: lasts exactly one cycle, then goes to IDLE.
- `start` in RUN or DONE is ignored; there is no queuing.
- `abort`=1 in RUN: go to IDLE on the next edge. No `done` pulse and no `chirp_last` are issued.
- `abort` takes priority over the end-of-chirp transition.
- `abort` in IDLE or DONE has no effect.
- Input ports are sampled only at the accepting `start`. Changing them mid-chirp has no effect.
- When `chirp_valid`=0, `phase_increment` is driven to 0 so the NCO holds a DC output.
- **Reset**: asynchronous. All outputs go to 0 immediately, the state goes to IDLE, the counter and accumulator clear, and any chirp in progress is lost.

## Timing
- All outputs are registered.
- **Start latency**: if `start` is sampled at edge N, sample 0 is presented after edge N+1, with `chirp_valid`=`chirp_first`=1 and `phase_increment`=f_start.
- Sample i appears after edge N+1+i, with one sample per clock and no gaps.
- `chirp_last` is asserted together with the final sample's `chirp_valid`.
- **`chirp_len`=1**: `chirp_first` and `chirp_last` are asserted in the same cycle.
- `done` is high in the cycle immediately after the last sample. `chirp_valid` is 0 in that cycle and `busy` is still 1.
- `busy` is high from edge N+1 through the DONE cycle. It falls the cycle after `done`.
- **Back-to-back chirps**: the earliest accepted `start` is the one sampled in the cycle after `done`. Minimum gap is 2 idle cycles between chirps.
- **Abort** sampled at edge M: after edge M, `chirp_valid`, `busy` and `phase_increment` are all 0.
- Total chirp duration is `chirp_len` cycles. The NCO adds its own latency downstream.

## Test plan
- **Basic ramp**: `f_start`=100, `k_step`=10, `chirp_len`=4, one `start` pulse → `phase_increment` = 100, 110, 120, 130 on 4 consecutive cycles, starting 1 cycle after `start`. `chirp_first` is on the first sample, `chirp_last` is on the 130 sample, and `done` follows one cycle later.
- **Wrap and downsweep**:
  - `f_start`=0xFFFFFFF0, `k_step`=0x10, len 3 → 0xFFFFFFF0, 0x00000000, 0x00000010.
  - `f_start`=5, `k_step`=0xFFFFFFFF, len 3 → 5, 4, 3.
- **Edge lengths**:
  - `chirp_len`=0 with `start` → `busy` stays 0 and no `chirp_valid` or `done` is produced.
  - `chirp_len`=1 → a single cycle with `chirp_first`=`chirp_last`=1, value `f_start`, then `done`.
- **Ignored start**: a second `start` at sample 2 of a 6-sample chirp, and another in the DONE cycle → exactly 6 samples are output and one `done` pulse. A `start` in the cycle after `done` launches a new chirp.
- **Abort**: `abort` at sample 3 of an 8-sample chirp → the next cycle has `chirp_valid`=`busy`=`phase_increment`=0, with no `done` and no `chirp_last`. A following `start` runs a full chirp normally.
- **Async reset mid-chirp**: assert `rst` between clock edges at sample 5 of 10 → all outputs are 0 before the next edge. After release, a 1 MHz chirp (`f_start`=42949673, `k_step`=0, len 200) feeds the NCO and gives a constant 1 MHz tone for 200 cycles.
